// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-addressed data memory with a one-cycle ack.
// Optional memory timeout with a BusErr pulse when MEM_TIMEOUT_EN is defined.
module mem_access_unit #(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [31:0]       Addr,
   input  logic [31:0]       WrData,
   output logic              Stall,
   output logic [31:0]       RdData,
   output logic              Fault,
   output logic              BusErr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   logic [2:0]  acc_funct3;
   logic [1:0]  acc_off;

   logic        req_any;
   logic        is_store;
   logic        size_ok;
   logic        align_ok;
   logic        valid_req;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] lane;
   logic [31:0] load_ext;

   wire unused_bits = ^{Addr[31:ADDR_W+2], TIMEOUT[0]};

   assign req_any  = MemRead | MemWrite;
   assign is_store = MemWrite;

   always_comb begin
      size_ok = 1'b0;
      case (Funct3)
         3'b000, 3'b001, 3'b010: size_ok = 1'b1;
         3'b100, 3'b101:         size_ok = ~is_store;
         default:                size_ok = 1'b0;
      endcase
   end

   always_comb begin
      align_ok = 1'b1;
      case (Funct3[1:0])
         2'b01:   align_ok = ~Addr[0];
         2'b10:   align_ok = (Addr[1:0] == 2'b00);
         default: align_ok = 1'b1;
      endcase
   end

   assign valid_req = req_any & size_ok & align_ok;

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = WrData;
      case (Funct3[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << Addr[1:0];
            wdata_calc = {4{WrData[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << Addr[1:0];
            wdata_calc = {2{WrData[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = WrData;
         end
      endcase
   end

   // Lane select uses the offset captured at issue, not the live Addr.
   assign lane = mem_rdata >> {acc_off, 3'b000};

   always_comb begin
      load_ext = lane;
      case (acc_funct3)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   assign Stall     = ((state == IDLE) && valid_req) || (state == WAIT);
   assign fsm_state = state;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] tcnt;
`else
   assign BusErr = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         RdData     <= '0;
         Fault      <= 1'b0;
         acc_funct3 <= '0;
         acc_off    <= '0;
`ifdef MEM_TIMEOUT_EN
         BusErr     <= 1'b0;
         tcnt       <= '0;
`endif
      end else begin
         Fault <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         BusErr <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (valid_req) begin
                  mem_req    <= 1'b1;
                  mem_we     <= is_store;
                  mem_addr   <= Addr[ADDR_W+1:2];
                  mem_be     <= be_calc;
                  mem_wdata  <= wdata_calc;
                  acc_funct3 <= Funct3;
                  acc_off    <= Addr[1:0];
`ifdef MEM_TIMEOUT_EN
                  tcnt       <= '0;
`endif
                  state      <= WAIT;
               end else if (req_any) begin
                  Fault <= 1'b1;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) RdData <= load_ext;
                  state   <= DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
                  mem_req <= 1'b0;
                  if (!mem_we) RdData <= '0;
                  BusErr  <= 1'b1;
                  state   <= DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected load results queued at issue, checked at DONE.
module tb_mem_access_unit;
   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              reset;
   logic              MemRead, MemWrite;
   logic [2:0]        Funct3;
   logic [31:0]       Addr, WrData;
   logic              Stall;
   logic [31:0]       RdData;
   logic              Fault, BusErr;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic [1:0]        fsm_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .Stall(Stall),
      .RdData(RdData), .Fault(Fault), .BusErr(BusErr), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .fsm_state(fsm_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Funct3   = 3'b000;
      Addr     = 32'd0;
      WrData   = 32'd0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " mem_req"},   32'(mem_req),   32'd0);
      check({tag, " mem_we"},    32'(mem_we),    32'd0);
      check({tag, " mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, " mem_wdata"}, mem_wdata,      32'd0);
      check({tag, " mem_be"},    32'(mem_be),    32'd0);
      check({tag, " RdData"},    RdData,         32'd0);
      check({tag, " Fault"},     32'(Fault),     32'd0);
      check({tag, " BusErr"},    32'(BusErr),    32'd0);
      check({tag, " Stall"},     32'(Stall),     32'd0);
      check({tag, " state"},     32'(fsm_state), 32'd0);
   endtask

   // One complete access; request stays asserted through DONE to show it is ignored there.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
      int stall_cycles;
      logic [31:0] exp_addr;
      logic [31:0] got_exp;
      stall_cycles = 0;
      exp_addr = {23'd0, addr[10:2]};
      MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = addr; WrData = wdata;
      mem_ack = 1'b0;
      exp_q.push_back(exp_rd);
      #1;
      if (Stall) stall_cycles++;
      step();
      check({tag, " req"},   32'(mem_req),  32'd1);
      check({tag, " we"},    32'(mem_we),   32'(wr));
      check({tag, " addr"},  32'(mem_addr), exp_addr);
      check({tag, " be"},    32'(mem_be),   32'(exp_be));
      check({tag, " wdata"}, mem_wdata,     exp_wdata);
      for (int i = 0; i < waits; i++) begin
         if (Stall) stall_cycles++;
         step();
         check({tag, " hold req"},   32'(mem_req),  32'd1);
         check({tag, " hold be"},    32'(mem_be),   32'(exp_be));
         check({tag, " hold wdata"}, mem_wdata,     exp_wdata);
         check({tag, " hold addr"},  32'(mem_addr), exp_addr);
      end
      mem_ack = 1'b1;
      mem_rdata = rdata;
      #1;
      if (Stall) stall_cycles++;
      step();
      mem_ack = 1'b0;
      mem_rdata = 32'hA5A5_5A5A;
      #1;
      check({tag, " done state"}, 32'(fsm_state), 32'd2);
      check({tag, " done stall"}, 32'(Stall),     32'd0);
      check({tag, " done req"},   32'(mem_req),   32'd0);
      if (exp_q.size() == 0) begin
         check({tag, " queue empty"}, 32'd0, 32'd1);
      end else begin
         got_exp = exp_q.pop_front();
         check({tag, " RdData"}, RdData, got_exp);
      end
      step();
      idle_inputs();
      #1;
      check({tag, " back idle"}, 32'(fsm_state), 32'd0);
      check({tag, " stall cycles"}, 32'(stall_cycles), 32'(waits + 2));
   endtask

   task automatic fault_case(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr);
      MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = addr; WrData = 32'hFFFF_FFFF;
      #1;
      check({tag, " no stall"}, 32'(Stall), 32'd0);
      step();
      idle_inputs();
      #1;
      check({tag, " fault"},  32'(Fault),     32'd1);
      check({tag, " no req"}, 32'(mem_req),   32'd0);
      check({tag, " idle"},   32'(fsm_state), 32'd0);
      step();
      check({tag, " fault drop"}, 32'(Fault), 32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      idle_inputs();
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      #12;
      check_reset_vals("reset");
      step();
      reset = 1'b1;
      step();

      access("LB 103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
             4'b1000, 32'h0, 32'hFFFF_FF80);
      access("SH 22", 0, 1, 3'b001, 32'h22, 32'h1234_ABCD, 32'hDEAD_BEEF, 3,
             4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80);
      access("LHU 2", 1, 0, 3'b101, 32'h2, 32'h0, 32'h8001_0000, 0,
             4'b1100, 32'h0, 32'h0000_8001);
      access("LH 2", 1, 0, 3'b001, 32'h2, 32'h0, 32'h8001_0000, 0,
             4'b1100, 32'h0, 32'hFFFF_8001);
      access("LW 8", 1, 0, 3'b010, 32'h8, 32'hCAFE_F00D, 32'h1234_5678, 1,
             4'b1111, 32'hCAFE_F00D, 32'h1234_5678);
      access("LBU 1", 1, 0, 3'b100, 32'h1, 32'h0, 32'h0000_A500, 0,
             4'b0010, 32'h0, 32'h0000_00A5);
      access("RW both", 1, 1, 3'b010, 32'h10, 32'h55AA_33CC, 32'h0BAD_0BAD, 0,
             4'b1111, 32'h55AA_33CC, 32'h0000_00A5);
      access("SB 3", 0, 1, 3'b000, 32'h7FF, 32'h0000_00EE, 32'h0, 2,
             4'b1000, 32'hEEEE_EEEE, 32'h0000_00A5);

      fault_case("LW 6",     1, 0, 3'b010, 32'h6);
      fault_case("L f3=011", 1, 0, 3'b011, 32'h8);
      fault_case("S f3=100", 0, 1, 3'b100, 32'h0);
      fault_case("LH 1",     1, 0, 3'b001, 32'h1);
      fault_case("SW 2",     0, 1, 3'b010, 32'h2);

      mem_ack = 1'b1;
      mem_rdata = 32'h7777_7777;
      step();
      mem_ack = 1'b0;
      #1;
      check("stray ack state",  32'(fsm_state), 32'd0);
      check("stray ack RdData", RdData,         32'h0000_00A5);
      check("stray ack req",    32'(mem_req),   32'd0);

`ifdef MEM_TIMEOUT_EN
      MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h4;
      step();
      n = 0;
      while (fsm_state == 2'd1 && n < 40) begin
         n++;
         step();
      end
      check("timeout wait cycles", 32'(n),         32'd15);
      check("timeout buserr",      32'(BusErr),    32'd1);
      check("timeout RdData",      RdData,         32'd0);
      check("timeout req",         32'(mem_req),   32'd0);
      check("timeout state",       32'(fsm_state), 32'd2);
      step();
      idle_inputs();
      #1;
      check("timeout buserr drop", 32'(BusErr), 32'd0);
`else
      MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h4;
      step();
      n = 0;
      repeat (20) begin
         step();
         n++;
      end
      check("no timeout state",  32'(fsm_state), 32'd1);
      check("no timeout buserr", 32'(BusErr),    32'd0);
      check("no timeout req",    32'(mem_req),   32'd1);
      mem_ack = 1'b1;
      mem_rdata = 32'h0000_0077;
      step();
      mem_ack = 1'b0;
      #1;
      check("late ack state",  32'(fsm_state), 32'd2);
      check("late ack RdData", RdData,         32'h0000_0077);
      step();
      idle_inputs();
`endif
      step();

      access("LW 8b", 1, 0, 3'b010, 32'h8, 32'h0, 32'h1357_2468, 0,
             4'b1111, 32'h0, 32'h1357_2468);
      MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h4;
      step();
      check("pre-reset req", 32'(mem_req), 32'd1);
      idle_inputs();
      reset = 1'b0;
      #1;
      check_reset_vals("mid-wait reset");
      step();
      reset = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      step();
      mem_ack = 1'b0;
      #1;
      check("post-reset ack state",  32'(fsm_state), 32'd0);
      check("post-reset ack RdData", RdData,         32'd0);
      check("post-reset ack req",    32'(mem_req),   32'd0);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning word-address width toward the data memory.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max wait cycles for mem_ack (used only under REQ-030).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemRead  in  1  load request from the main decoder.
REQ-006 SHALL have port MemWrite  in  1  store request from the main decoder.
REQ-007 SHALL have port Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port Addr  in  32  byte address from the ALU.
REQ-009 SHALL have port WrData  in  32  store data, rs2 value.
REQ-010 SHALL have port Stall  out  1  holds the pipeline while an access is in progress.
REQ-011 SHALL have port RdData  out  32  extended load result.
REQ-012 SHALL have port Fault  out  1  one-cycle pulse: misaligned or illegal size.
REQ-013 SHALL have port BusErr  out  1  one-cycle pulse: memory timeout.
REQ-014 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W (Addr[ADDR_W+1:2]), mem_wdata out 32, mem_be out 4.
REQ-015 SHALL have ports mem_ack in 1 (one-cycle completion) and mem_rdata in 32 (valid with mem_ack).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-017 IDLE: a valid request (MemRead|MemWrite, legal Funct3, aligned Addr) SHALL register addr/be/wdata/we, set mem_req=1, go to WAIT.
REQ-018 Stall SHALL be combinational: 1 when (IDLE and valid request) or WAIT; 0 in DONE and otherwise.
REQ-019 WAIT: mem_req, mem_we, mem_addr, mem_be, mem_wdata SHALL stay stable until mem_ack=1.
REQ-020 On mem_ack in WAIT: mem_req->0, RdData<=extended mem_rdata (loads only; stores leave RdData unchanged), go to DONE.
REQ-021 DONE SHALL last exactly one cycle, ignore MemRead/MemWrite, return to IDLE; minimum access latency is 3 cycles (IDLE->WAIT->DONE) with 0-wait memory.
REQ-022 Alignment: H/HU need Addr[0]=0; W needs Addr[1:0]=00; B/BU are always aligned.
REQ-023 Misaligned access or illegal Funct3 (011,110,111; stores also 100,101) SHALL issue no memory request, no Stall; Fault=1 on the next cycle for one cycle.
REQ-024 Byte enables: B=4'b0001<<Addr[1:0]; H=4'b0011<<Addr[1:0]; W=4'b1111.
REQ-025 Store data SHALL be replicated: SB {4{WrData[7:0]}}, SH {2{WrData[15:0]}}, SW WrData.
REQ-026 Load extraction SHALL select the lane by Addr[1:0]; B/H sign-extend, BU/HU zero-extend.
REQ-027 MemRead and MemWrite both 1 SHALL be treated as a store (MemWrite priority).
REQ-028 mem_ack outside WAIT SHALL be ignored.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, RdData=0, Fault=0, BusErr=0, timeout counter=0; a reset during WAIT abandons the access, and a following mem_ack is ignored.

Configuration
REQ-030 With MEM_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT; if TIMEOUT cycles pass without mem_ack, then mem_req->0, RdData<=0 for a load, BusErr pulses one cycle, go to DONE.
REQ-031 Without MEM_TIMEOUT_EN: no counter; WAIT SHALL persist until mem_ack; BusErr SHALL be tied 0.

Verification
REQ-032 LB Addr=0x103, mem_rdata=0x80FF_0000 with ack on 1st WAIT cycle -> mem_be=1000, mem_addr=0x40, RdData=0xFFFF_FF80, Stall high 2 cycles.
REQ-033 SH Addr=0x22, WrData=0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, held stable over 3 wait cycles until ack.
REQ-034 LW Addr=0x6 -> no mem_req, Stall=0, Fault=1 for exactly one cycle; Funct3=011 load at Addr=0x8 -> same response.
REQ-035 LHU Addr=0x2, mem_rdata=0x8001_0000 -> RdData=0x0000_8001; same access as LH -> RdData=0xFFFF_8001.
REQ-036 reset=0 mid-WAIT, then mem_ack -> all outputs at reset values, FSM stays IDLE; with MEM_TIMEOUT_EN and no ack -> BusErr pulse after 15 WAIT cycles, RdData=0.
